// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sram_arb_pkg : state encoding and default sizing for sram_arbiter
// Rev 1.0
// ------------------------------------------------------------------
package sram_arb_pkg;

  localparam int ADDR_W_DEF  = 19;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_arb_rr.sv
`default_nettype none
// ------------------------------------------------------------------
// sram_arb_rr : two-way round-robin grant (one-hot, combinational)
// Rev 1.0
// ------------------------------------------------------------------
module sram_arb_rr (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // last_i = 1 means port 1 was served last, so port 0 wins a tie
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// sram_arbiter : two-port round-robin front end for one SRAM controller
// Rev 1.0
// ------------------------------------------------------------------
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_in,
  input  logic              p0_rw_in,
  input  logic [ADDR_W-1:0] p0_addr_in,
  input  logic [DATA_W-1:0] p0_wdata_in,
  output logic              p0_ack_out,
  output logic [DATA_W-1:0] p0_rdata_out,
  output logic              p0_err_out,
  input  logic              p1_req_in,
  input  logic              p1_rw_in,
  input  logic [ADDR_W-1:0] p1_addr_in,
  input  logic [DATA_W-1:0] p1_wdata_in,
  output logic              p1_ack_out,
  output logic [DATA_W-1:0] p1_rdata_out,
  output logic              p1_err_out,
  output logic              mem_trig_out,
  output logic              mem_rw_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  input  logic [DATA_W-1:0] mem_rdata_in,
  input  logic              mem_done_in
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              last_q;
  logic              mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [1:0]        gnt;
  logic              grant_en;
  logic              capture;
  logic              timeout;
  logic              resp;

  sram_arb_rr u_rr (
    .req_i  ({p1_req_in, p0_req_in}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  // >= rather than == so a count that overshoots in WAIT_LO still expires
  assign timeout = (cnt_q >= CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    grant_en = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (p0_req_in || p1_req_in) begin
          grant_en = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        cnt_d = cnt_q + 1'b1;
        if (!mem_done_in) begin
          state_d = ST_WAIT_HI;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WAIT_HI: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_done_in) begin
          capture = mem_rw_q;
          state_d = ST_RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // last_q doubles as the grant of the transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      err_q       <= 1'b0;
      last_q      <= 1'b1;
      mem_rw_q    <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (grant_en) begin
        last_q <= gnt[1];
        if (gnt[0]) begin
          mem_rw_q    <= p0_rw_in;
          mem_addr_q  <= p0_addr_in;
          mem_wdata_q <= p0_wdata_in;
        end else begin
          mem_rw_q    <= p1_rw_in;
          mem_addr_q  <= p1_addr_in;
          mem_wdata_q <= p1_wdata_in;
        end
      end
      if (capture) begin
        if (last_q) begin
          rdata1_q <= mem_rdata_in;
        end else begin
          rdata0_q <= mem_rdata_in;
        end
      end
    end
  end

  always_comb begin
    mem_trig_out = (state_q == ST_ISSUE);
    resp         = (state_q == ST_RESP);
    p0_ack_out   = resp && !last_q;
    p1_ack_out   = resp && last_q;
    p0_err_out   = resp && !last_q && err_q;
    p1_err_out   = resp && last_q && err_q;
  end

  assign mem_rw_out    = mem_rw_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_wdata_out = mem_wdata_q;
  assign p0_rdata_out  = rdata0_q;
  assign p1_rdata_out  = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_sram_arbiter : scoreboard bench for sram_arbiter with an SRAM model
// Rev 1.0
// ------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int TIMEOUT = 16;

  typedef struct {
    bit          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    bit          port;
    bit          err;
    logic [DW-1:0] rdata;
    int          lat;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req = 1'b0, p0_rw = 1'b0, p1_req = 1'b0, p1_rw = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_ack_out, p1_ack_out, p0_err_out, p1_err_out;
  logic [DW-1:0] p0_rdata_out, p1_rdata_out;
  logic          mem_trig_out, mem_rw_out;
  logic [AW-1:0] mem_addr_out;
  logic [DW-1:0] mem_wdata_out;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_done = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int trig_cyc = 0;
  int last_ack_cyc = 0;
  bit have_ack = 0;
  bit outstanding = 0;
  int mdl_busy = 2;
  bit mdl_stuck = 0;
  int left = 0;
  cmd_t cur;
  cmd_t cmdq[$];
  rsp_t rspq[$];
  logic [DW-1:0] exp_rd [2];

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .p0_req_in     (p0_req),
    .p0_rw_in      (p0_rw),
    .p0_addr_in    (p0_addr),
    .p0_wdata_in   (p0_wdata),
    .p0_ack_out    (p0_ack_out),
    .p0_rdata_out  (p0_rdata_out),
    .p0_err_out    (p0_err_out),
    .p1_req_in     (p1_req),
    .p1_rw_in      (p1_rw),
    .p1_addr_in    (p1_addr),
    .p1_wdata_in   (p1_wdata),
    .p1_ack_out    (p1_ack_out),
    .p1_rdata_out  (p1_rdata_out),
    .p1_err_out    (p1_err_out),
    .mem_trig_out  (mem_trig_out),
    .mem_rw_out    (mem_rw_out),
    .mem_addr_out  (mem_addr_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_rdata_in  (mem_rdata),
    .mem_done_in   (mem_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // The memory model answers every read of address A with A[7:0] ^ 0xB5.
  task automatic push_exp(input bit p, input bit rw, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit to, input bit abort);
    cmd_t c;
    rsp_t r;
    c.rw = rw; c.addr = a; c.wdata = d;
    cmdq.push_back(c);
    if (!abort) begin
      if (rw && !to) exp_rd[p] = a[7:0] ^ 8'hB5;
      r.port  = p;
      r.err   = to;
      r.rdata = exp_rd[p];
      r.lat   = to ? TIMEOUT + 1 : mdl_busy + 1;
      rspq.push_back(r);
    end
  endtask

  task automatic port_req(input bit p, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 0;
    if (!p) begin p0_req = 1; p0_rw = rw; p0_addr = a; p0_wdata = d; end
    else    begin p1_req = 1; p1_rw = rw; p1_addr = a; p1_wdata = d; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = p ? p1_ack_out : p0_ack_out;
    end
    check(p ? "p1_ack_wait" : "p0_ack_wait", 32'(got), 1);
    if (!p) p0_req = 0; else p1_req = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_p0_ack",  32'(p0_ack_out), 0);
    check("rst_p1_ack",  32'(p1_ack_out), 0);
    check("rst_p0_err",  32'(p0_err_out), 0);
    check("rst_p1_err",  32'(p1_err_out), 0);
    check("rst_trig",    32'(mem_trig_out), 0);
    check("rst_mem_rw",  32'(mem_rw_out), 1);
    check("rst_mem_addr", 32'(mem_addr_out), 0);
    check("rst_mem_wdata", 32'(mem_wdata_out), 0);
    check("rst_p0_rdata", 32'(p0_rdata_out), 0);
    check("rst_p1_rdata", 32'(p1_rdata_out), 0);
  endtask

  // SRAM controller model: done drops on the trig cycle, rises mdl_busy cycles later
  always @(negedge clk) begin
    if (rst) begin
      left = 0;
      mem_done = 1'b1;
      outstanding = 0;
    end else if (mem_trig_out) begin
      check("trig_overlap", 32'(outstanding), 0);
      outstanding = 1;
      if (have_ack) check("idle_gap", 32'((cyc - last_ack_cyc) >= 2), 1);
      trig_cyc = cyc;
      if (cmdq.size() == 0) begin
        check("unexpected_trig", 32'(cmdq.size()), 1);
      end else begin
        cur = cmdq.pop_front();
        check("cmd_rw",    32'(mem_rw_out),    32'(cur.rw));
        check("cmd_addr",  32'(mem_addr_out),  32'(cur.addr));
        check("cmd_wdata", 32'(mem_wdata_out), 32'(cur.wdata));
      end
      if (!mdl_stuck) begin
        mem_done = 1'b0;
        left = mdl_busy;
      end
    end else if (left > 0) begin
      left--;
      if (left == 0) begin
        check("hold_rw",    32'(mem_rw_out),    32'(cur.rw));
        check("hold_addr",  32'(mem_addr_out),  32'(cur.addr));
        check("hold_wdata", 32'(mem_wdata_out), 32'(cur.wdata));
        mem_rdata = cur.addr[7:0] ^ 8'hB5;
        mem_done = 1'b1;
      end
    end
  end

  // Monitor: every ack pops one expected response
  always @(negedge clk) begin
    rsp_t e;
    if (!rst) begin
      check("err_without_ack", 32'((p0_err_out && !p0_ack_out) || (p1_err_out && !p1_ack_out)), 0);
      if (p0_ack_out || p1_ack_out) begin
        check("ack_onehot", 32'(p0_ack_out && p1_ack_out), 0);
        if (rspq.size() == 0) begin
          check("unexpected_ack", 32'(rspq.size()), 1);
        end else begin
          e = rspq.pop_front();
          check("ack_port", 32'(p1_ack_out), 32'(e.port));
          check("ack_err",  32'(e.port ? p1_err_out : p0_err_out), 32'(e.err));
          check("ack_rdata", 32'(e.port ? p1_rdata_out : p0_rdata_out), 32'(e.rdata));
          check("ack_latency", 32'(cyc - trig_cyc), 32'(e.lat));
        end
        outstanding = 0;
        have_ack = 1;
        last_ack_cyc = cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 0;
    @(negedge clk);

    // Simultaneous requests, both held: p0, p1, p0
    push_exp(0, 1, 19'h00020, 8'h00, 0, 0);
    push_exp(1, 1, 19'h00100, 8'h00, 0, 0);
    push_exp(0, 0, 19'h00030, 8'h77, 0, 0);
    fork
      begin
        port_req(0, 1, 19'h00020, 8'h00);
        port_req(0, 0, 19'h00030, 8'h77);
      end
      port_req(1, 1, 19'h00100, 8'h00);
    join
    repeat (2) @(negedge clk);

    // Single p0 read, expected data 0xA5
    push_exp(0, 1, 19'h00010, 8'h00, 0, 0);
    port_req(0, 1, 19'h00010, 8'h00);
    @(negedge clk);

    // p1 write to upper byte bank; p1 rdata stays 0xB5
    push_exp(1, 0, 19'h40003, 8'h3C, 0, 0);
    port_req(1, 0, 19'h40003, 8'h3C);
    @(negedge clk);

    // Controller never goes busy: timeout, then a normal p1 read
    mdl_stuck = 1;
    push_exp(0, 1, 19'h00055, 8'h00, 1, 0);
    port_req(0, 1, 19'h00055, 8'h00);
    mdl_stuck = 0;
    push_exp(1, 1, 19'h00077, 8'h00, 0, 0);
    port_req(1, 1, 19'h00077, 8'h00);

    // Back-to-back p0 reads
    for (int i = 1; i <= 3; i++) push_exp(0, 1, 19'(32'h100 + i), 8'h00, 0, 0);
    for (int i = 1; i <= 3; i++) port_req(0, 1, 19'(32'h100 + i), 8'h00);
    repeat (2) @(negedge clk);

    // Reset while in WAIT_HI; held request is re-issued afterwards
    mdl_busy = 6;
    push_exp(0, 1, 19'h00200, 8'h00, 0, 1);
    fork
      port_req(0, 1, 19'h00200, 8'h00);
      begin
        for (int i = 0; i < 50 && !mem_trig_out; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check_reset_outputs();
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        push_exp(0, 1, 19'h00200, 8'h00, 0, 0);
        @(negedge clk);
        rst = 0;
      end
    join
    mdl_busy = 2;

    repeat (5) @(negedge clk);
    check("queues_drained", 32'(rspq.size() + cmdq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
